// File: rtl/rec_play_ctrl.sv
// rtl/rec_play_ctrl.sv - record/playback sequencer with SRAM port arbitration
// Sequences recorder and player from key pulses and latches the recorded length.
module rec_play_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_done,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  input  logic              i_rec_valid,
  input  logic              i_rec_finish,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  input  logic [ADDR_W-1:0] i_play_addr,
  input  logic              i_play_finish,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_we,
  output logic              o_sram_oe,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_end_valid,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_REC        = 3'd2,
    S_REC_PAUSE  = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  state_t state;

  // Recording ends on a stop key or when the recorder writes the last SRAM word.
  logic rec_hit_end;
  logic play_hit_end;
  assign rec_hit_end  = i_rec_valid && (i_rec_addr == MAX_ADDR);
  assign play_hit_end = (i_play_addr >= o_end_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_INIT;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
      o_end_addr   <= '0;
      o_end_valid  <= 1'b0;
    end else begin
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
      case (state)
        S_INIT: begin
          if (i_init_done) state <= S_IDLE;
        end
        S_IDLE: begin
          if (i_key_rec) begin
            state       <= S_REC;
            o_rec_start <= 1'b1;
          end else if (i_key_play && o_end_valid) begin
            state        <= S_PLAY;
            o_play_start <= 1'b1;
          end
        end
        S_REC: begin
          if (i_key_stop || rec_hit_end) begin
            state       <= S_IDLE;
            o_rec_stop  <= 1'b1;
            o_end_addr  <= i_rec_addr;
            o_end_valid <= 1'b1;
          end else if (i_rec_finish) begin
            state       <= S_IDLE;
            o_end_addr  <= i_rec_addr;
            o_end_valid <= 1'b1;
          end else if (i_key_pause) begin
            state       <= S_REC_PAUSE;
            o_rec_pause <= 1'b1;
          end
        end
        S_REC_PAUSE: begin
          if (i_key_stop) begin
            state       <= S_IDLE;
            o_rec_stop  <= 1'b1;
            o_end_addr  <= i_rec_addr;
            o_end_valid <= 1'b1;
          end else if (i_key_pause) begin
            state       <= S_REC;
            o_rec_pause <= 1'b1;
          end
        end
        S_PLAY: begin
          if (i_key_stop || play_hit_end) begin
            state       <= S_IDLE;
            o_play_stop <= 1'b1;
          end else if (i_play_finish) begin
            state <= S_IDLE;
          end else if (i_key_pause) begin
            state        <= S_PLAY_PAUSE;
            o_play_pause <= 1'b1;
          end
        end
        S_PLAY_PAUSE: begin
          if (i_key_stop) begin
            state       <= S_IDLE;
            o_play_stop <= 1'b1;
          end else if (i_key_pause) begin
            state        <= S_PLAY;
            o_play_pause <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // SRAM port follows the registered state with no extra latency.
  always_comb begin
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    o_sram_we    = 1'b0;
    o_sram_oe    = 1'b0;
    case (state)
      S_REC: begin
        o_sram_addr  = i_rec_addr;
        o_sram_wdata = i_rec_data;
        o_sram_we    = i_rec_valid;
      end
      S_REC_PAUSE: begin
        o_sram_addr  = i_rec_addr;
        o_sram_wdata = i_rec_data;
      end
      S_PLAY, S_PLAY_PAUSE: begin
        o_sram_addr = i_play_addr;
        o_sram_oe   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// tb/tb_rec_play_ctrl.sv - directed plus randomized bench for rec_play_ctrl
// Compares every output each cycle against a behavioural model of the sequencer.
module tb_rec_play_ctrl;
  localparam logic [19:0] MAXA = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        rst, init_done, key_rec, key_play, key_pause, key_stop;
  logic        rec_start, rec_pause, rec_stop;
  logic [19:0] rec_addr;
  logic [15:0] rec_data;
  logic        rec_valid, rec_finish;
  logic        play_start, play_pause, play_stop;
  logic [19:0] play_addr;
  logic        play_finish;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we, sram_oe;
  logic [19:0] end_addr;
  logic        end_valid;
  logic [2:0]  state;

  always #5 clk = ~clk;

  rec_play_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
    .i_key_rec(key_rec), .i_key_play(key_play), .i_key_pause(key_pause), .i_key_stop(key_stop),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
    .i_rec_addr(rec_addr), .i_rec_data(rec_data), .i_rec_valid(rec_valid), .i_rec_finish(rec_finish),
    .o_play_start(play_start), .o_play_pause(play_pause), .o_play_stop(play_stop),
    .i_play_addr(play_addr), .i_play_finish(play_finish),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_we(sram_we), .o_sram_oe(sram_oe),
    .o_end_addr(end_addr), .o_end_valid(end_valid), .o_state(state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode number, "recording exists" flag, remembered length, and pulse flags.
  int          m_mode;
  logic [19:0] m_len;
  bit          m_have;
  bit          m_rs, m_rp, m_rt, m_ps, m_pp, m_pt;

  task automatic model_step();
    bool_clear();
    if (rst) begin
      m_mode = 0; m_len = '0; m_have = 0;
      return;
    end
    if (m_mode == 0) begin
      if (init_done) m_mode = 1;
    end else if (m_mode == 1) begin
      if (key_rec) begin m_mode = 2; m_rs = 1; end
      else if (key_play && m_have) begin m_mode = 4; m_ps = 1; end
    end else if (m_mode == 2 || m_mode == 3) begin
      bit ends = key_stop || (m_mode == 2 && rec_valid && rec_addr == MAXA);
      bit fin  = (m_mode == 2) && rec_finish;
      if (ends || fin) begin
        m_rt = ends; m_len = rec_addr; m_have = 1; m_mode = 1;
      end else if (key_pause) begin
        m_rp = 1; m_mode = (m_mode == 2) ? 3 : 2;
      end
    end else begin
      bit ends = key_stop || (m_mode == 4 && play_addr >= m_len);
      if (ends) begin m_pt = 1; m_mode = 1; end
      else if (m_mode == 4 && play_finish) m_mode = 1;
      else if (key_pause) begin m_pp = 1; m_mode = (m_mode == 4) ? 5 : 4; end
    end
  endtask

  task automatic bool_clear();
    m_rs = 0; m_rp = 0; m_rt = 0; m_ps = 0; m_pp = 0; m_pt = 0;
  endtask

  task automatic compare_all();
    bit recording = (m_mode == 2 || m_mode == 3);
    bit playing   = (m_mode == 4 || m_mode == 5);
    check("state", state, m_mode);
    check("rec_start", rec_start, m_rs);
    check("rec_pause", rec_pause, m_rp);
    check("rec_stop", rec_stop, m_rt);
    check("play_start", play_start, m_ps);
    check("play_pause", play_pause, m_pp);
    check("play_stop", play_stop, m_pt);
    check("end_addr", end_addr, m_len);
    check("end_valid", end_valid, m_have);
    check("sram_addr", sram_addr, recording ? rec_addr : (playing ? play_addr : 20'h0));
    check("sram_wdata", sram_wdata, recording ? rec_data : 16'h0);
    check("sram_we", sram_we, (m_mode == 2) && rec_valid);
    check("sram_oe", sram_oe, playing);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_keys();
    key_rec = 0; key_play = 0; key_pause = 0; key_stop = 0;
  endtask

  initial begin
    rst = 1; init_done = 0; clear_keys();
    rec_addr = '0; rec_data = 16'hA5A5; rec_valid = 0; rec_finish = 0;
    play_addr = '0; play_finish = 0;
    m_mode = 0; m_len = '0; m_have = 0; bool_clear();

    cycle();
    rst = 0;
    check("reset_state", state, 3'd0);
    check("reset_end_valid", end_valid, 1'b0);
    check("reset_sram_we", sram_we, 1'b0);
    init_done = 1;
    cycle();
    check("init_to_idle", state, 3'd1);

    key_play = 1; cycle(); clear_keys();
    check("play_no_rec", play_start, 1'b0);
    check("play_no_rec_state", state, 3'd1);

    key_rec = 1; rec_valid = 1; rec_addr = 20'h5; cycle(); clear_keys();
    check("rec_start_pulse", rec_start, 1'b1);
    check("rec_state", state, 3'd2);
    check("rec_we", sram_we, 1'b1);
    cycle();
    check("rec_start_one_cycle", rec_start, 1'b0);

    key_pause = 1; cycle(); clear_keys();
    check("rec_pause1", rec_pause, 1'b1);
    check("rec_paused_state", state, 3'd3);
    check("rec_paused_we", sram_we, 1'b0);
    repeat (49) cycle();
    key_pause = 1; cycle(); clear_keys();
    check("rec_pause2", rec_pause, 1'b1);
    check("rec_resumed_state", state, 3'd2);

    rec_addr = 20'h00123; key_stop = 1; cycle(); clear_keys();
    check("rec_stop_pulse", rec_stop, 1'b1);
    check("end_addr_123", end_addr, 20'h00123);
    check("end_valid_set", end_valid, 1'b1);
    check("rec_stop_state", state, 3'd1);

    key_rec = 1; cycle(); clear_keys();
    rec_addr = 20'h00010; key_stop = 1; cycle(); clear_keys();
    check("end_addr_10", end_addr, 20'h00010);
    rec_valid = 0;

    key_play = 1; play_addr = 0; cycle(); clear_keys();
    check("play_start_pulse", play_start, 1'b1);
    check("play_oe", sram_oe, 1'b1);
    for (int a = 0; a < 16; a++) begin
      play_addr = 20'(a); cycle();
    end
    check("play_before_end", state, 3'd4);
    play_addr = 20'h00010; cycle();
    check("play_end_stop", play_stop, 1'b1);
    check("play_end_state", state, 3'd1);

    key_rec = 1; cycle(); clear_keys();
    rec_valid = 1; rec_addr = MAXA; cycle();
    check("max_stop", rec_stop, 1'b1);
    check("max_end_addr", end_addr, 20'hFFFFF);
    rec_addr = 20'h7;
    key_rec = 1; cycle(); clear_keys();
    key_stop = 1; key_pause = 1; cycle(); clear_keys();
    check("stop_beats_pause_state", state, 3'd1);
    check("stop_beats_pause_nopause", rec_pause, 1'b0);
    check("stop_beats_pause_stop", rec_stop, 1'b1);

    key_play = 1; play_addr = 0; cycle(); clear_keys();
    check("play_again", state, 3'd4);
    rst = 1; cycle(); rst = 0;
    check("rst_play_state", state, 3'd0);
    check("rst_play_valid", end_valid, 1'b0);
    check("rst_play_nostop", play_stop, 1'b0);
    check("rst_play_oe", sram_oe, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 599) == 0);
      init_done   = ($urandom_range(0, 3) != 0);
      key_rec     = ($urandom_range(0, 11) == 0);
      key_play    = ($urandom_range(0, 9) == 0);
      key_pause   = ($urandom_range(0, 9) == 0);
      key_stop    = ($urandom_range(0, 19) == 0);
      rec_valid   = $urandom_range(0, 1) == 1;
      rec_addr    = ($urandom_range(0, 39) == 0) ? MAXA : 20'($urandom_range(0, 255));
      rec_data    = 16'($urandom);
      rec_finish  = ($urandom_range(0, 39) == 0);
      play_addr   = 20'($urandom_range(0, 300));
      play_finish = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
